// File: rtl/vc_queue.sv
// vc_queue: CH_NUM independent circular FIFOs that share one write port and
// one first-word-fall-through read port, both selected by channel number.
// Each channel has its own write pointer, read pointer and occupancy count,
// and reports full / empty / almost_full flags derived from its count.
// A write to a full channel and a read from an empty channel are discarded.
// A channel number >= CH_NUM counts as no access.
// Optional build macro: VC_QUEUE_ERR_EN adds the sticky outputs err_ovf
// (dropped write) and err_udf (ignored read), which only a_rst clears.

module vc_queue #(
    parameter int DATA_SIZE = 4,
    parameter int PTR_SIZE  = 2,
    parameter int CH_NUM    = 4,
    parameter int CH_W      = 2,
    parameter int AF_LEVEL  = 3
) (
    input  logic                              clk,
    input  logic                              a_rst,
    input  logic                              wr_req,
    input  logic [CH_W-1:0]                   wr_ch,
    input  logic [DATA_SIZE-1:0]              data_i,
    input  logic                              r_req,
    input  logic [CH_W-1:0]                   r_ch,
    output logic [DATA_SIZE-1:0]              data_o,
    output logic [CH_NUM-1:0]                 full,
    output logic [CH_NUM-1:0]                 empty,
    output logic [CH_NUM-1:0]                 almost_full,
    output logic [CH_NUM*(PTR_SIZE+1)-1:0]    count
`ifdef VC_QUEUE_ERR_EN
    ,
    output logic                              err_ovf,
    output logic                              err_udf
`endif
);

    localparam int                DEPTH    = 1 << PTR_SIZE;
    localparam logic [PTR_SIZE:0] FULL_CNT = (PTR_SIZE+1)'(DEPTH);
    localparam logic [PTR_SIZE:0] AF_CNT   = (PTR_SIZE+1)'(AF_LEVEL);
    localparam logic [CH_W:0]     CH_LIM   = (CH_W+1)'(CH_NUM);

    logic [PTR_SIZE:0]     cnt_r    [CH_NUM];
    logic [PTR_SIZE-1:0]   wr_ptr_r [CH_NUM];
    logic [PTR_SIZE-1:0]   rd_ptr_r [CH_NUM];
    logic [DATA_SIZE-1:0]  mem_r    [CH_NUM][DEPTH];

    logic                  wr_sel;
    logic                  rd_sel;
    logic                  wr_full;
    logic                  rd_empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [CH_NUM-1:0]     wr_en;
    logic [CH_NUM-1:0]     rd_en;

    // Qualify both strobes by channel range, then by the target's current count.
    always_comb begin
        wr_sel   = wr_req && ({1'b0, wr_ch} < CH_LIM);
        rd_sel   = r_req  && ({1'b0, r_ch}  < CH_LIM);
        wr_full  = 1'b0;
        rd_empty = 1'b0;
        if (wr_sel) wr_full  = (cnt_r[wr_ch] == FULL_CNT);
        if (rd_sel) rd_empty = (cnt_r[r_ch] == '0);
        wr_acc   = wr_sel && !wr_full;
        rd_acc   = rd_sel && !rd_empty;
        wr_en    = '0;
        rd_en    = '0;
        if (wr_acc) wr_en[wr_ch] = 1'b1;
        if (rd_acc) rd_en[r_ch]  = 1'b1;
    end

    // Per-channel pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            for (int i = 0; i < CH_NUM; i++) begin
                cnt_r[i]    <= '0;
                wr_ptr_r[i] <= '0;
                rd_ptr_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (wr_en[i]) wr_ptr_r[i] <= wr_ptr_r[i] + PTR_SIZE'(1);
                if (rd_en[i]) rd_ptr_r[i] <= rd_ptr_r[i] + PTR_SIZE'(1);
                if (wr_en[i] && !rd_en[i])
                    cnt_r[i] <= cnt_r[i] + (PTR_SIZE+1)'(1);
                else if (rd_en[i] && !wr_en[i])
                    cnt_r[i] <= cnt_r[i] - (PTR_SIZE+1)'(1);
            end
        end
    end

    // Storage is deliberately not reset; stale entries are hidden by the counts.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_r[wr_ch][wr_ptr_r[wr_ch]] <= data_i;
    end

    // Status flags and packed counts come straight from the registered counts.
    always_comb begin
        full        = '0;
        empty       = '0;
        almost_full = '0;
        count       = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            full[i]        = (cnt_r[i] == FULL_CNT);
            empty[i]       = (cnt_r[i] == '0);
            almost_full[i] = (cnt_r[i] >= AF_CNT);
            count[i*(PTR_SIZE+1) +: PTR_SIZE+1] = cnt_r[i];
        end
    end

    // First-word-fall-through head of the selected channel, zero when empty.
    always_comb begin
        data_o = '0;
        if ({1'b0, r_ch} < CH_LIM) begin
            if (cnt_r[r_ch] != '0) data_o = mem_r[r_ch][rd_ptr_r[r_ch]];
        end
    end

`ifdef VC_QUEUE_ERR_EN
    // Sticky overflow / underflow records, visible the edge after the event.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_sel && wr_full)  err_ovf <= 1'b1;
            if (rd_sel && rd_empty) err_udf <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_vc_queue.sv
// Bench for vc_queue (2 channels, depth 4, almost-full at 3).
// The driver keeps a queue-per-channel reference model and pushes the
// expected visible state for every cycle into a scoreboard; a monitor on the
// falling edge pops each entry and compares it with the DUT outputs.

module tb_vc_queue;

    logic       clk;
    logic       a_rst;
    logic       wr_req;
    logic [0:0] wr_ch;
    logic [3:0] data_i;
    logic       r_req;
    logic [0:0] r_ch;
    logic [3:0] data_o;
    logic [1:0] full;
    logic [1:0] empty;
    logic [1:0] almost_full;
    logic [5:0] count;
`ifdef VC_QUEUE_ERR_EN
    logic       err_ovf;
    logic       err_udf;
`endif

    vc_queue #(
        .DATA_SIZE(4), .PTR_SIZE(2), .CH_NUM(2), .CH_W(1), .AF_LEVEL(3)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .wr_req(wr_req), .wr_ch(wr_ch), .data_i(data_i),
        .r_req(r_req), .r_ch(r_ch), .data_o(data_o),
        .full(full), .empty(empty), .almost_full(almost_full), .count(count)
`ifdef VC_QUEUE_ERR_EN
        , .err_ovf(err_ovf), .err_udf(err_udf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int c0;
        int c1;
        int dout;
        bit ovf;
        bit udf;
    } exp_t;

    exp_t sb[$];
    int   mq0[$];
    int   mq1[$];
    bit   m_ovf;
    bit   m_udf;
    int   n_cmp;
    int   n_bad;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; records what the DUT must show before the edge.
    task automatic cycle(input bit w, input bit wc, input int d,
                         input bit r, input bit rc);
        exp_t e;
        int   sw;
        int   sr;
        @(posedge clk);
        #1;
        wr_req = w;
        wr_ch  = wc;
        data_i = 4'(d);
        r_req  = r;
        r_ch   = rc;
        e.c0   = mq0.size();
        e.c1   = mq1.size();
        e.ovf  = m_ovf;
        e.udf  = m_udf;
        if (rc == 1'b0) e.dout = (mq0.size() > 0) ? mq0[0] : 0;
        else            e.dout = (mq1.size() > 0) ? mq1[0] : 0;
        sb.push_back(e);
        sw = wc ? mq1.size() : mq0.size();
        sr = rc ? mq1.size() : mq0.size();
        if (w && sw == 4) m_ovf = 1'b1;
        if (r && sr == 0) m_udf = 1'b1;
        if (r && sr > 0) begin
            if (rc) void'(mq1.pop_front());
            else    void'(mq0.pop_front());
        end
        if (w && sw < 4) begin
            if (wc) mq1.push_back(d & 15);
            else    mq0.push_back(d & 15);
        end
    endtask

    task automatic idle(input bit rc);
        cycle(1'b0, 1'b0, 0, 1'b0, rc);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, int'(empty), 3);
        chk({tag, "_full"},  int'(full), 0);
        chk({tag, "_af"},    int'(almost_full), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_dout"},  int'(data_o), 0);
`ifdef VC_QUEUE_ERR_EN
        chk({tag, "_ovf"},   int'(err_ovf), 0);
        chk({tag, "_udf"},   int'(err_udf), 0);
`endif
    endtask

    // Monitor: compares every cycle's visible outputs with the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("count0", int'(count[2:0]), e.c0);
                chk("count1", int'(count[5:3]), e.c1);
                chk("empty",  int'(empty), ((e.c1 == 0) ? 2 : 0) + ((e.c0 == 0) ? 1 : 0));
                chk("full",   int'(full),  ((e.c1 == 4) ? 2 : 0) + ((e.c0 == 4) ? 1 : 0));
                chk("af",     int'(almost_full), ((e.c1 >= 3) ? 2 : 0) + ((e.c0 >= 3) ? 1 : 0));
                chk("data_o", int'(data_o), e.dout);
`ifdef VC_QUEUE_ERR_EN
                chk("err_ovf", int'(err_ovf), int'(e.ovf));
                chk("err_udf", int'(err_udf), int'(e.udf));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        a_rst  = 1'b1;
        wr_req = 1'b0;
        wr_ch  = 1'b0;
        data_i = 4'd0;
        r_req  = 1'b0;
        r_ch   = 1'b0;
        #12;
        chk_reset_state("por");
        #5;
        a_rst = 1'b0;

        // Fill ch0 with 1..4, then drain in order.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, i, 1'b0, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        idle(1'b0);

        // Full ch0: simultaneous write and read drops the write only.
        for (int i = 6; i <= 9; i++) cycle(1'b1, 1'b0, i, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 5, 1'b1, 1'b0);
        idle(1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // ch0 holds 7; write ch1=A while reading ch0.
        cycle(1'b1, 1'b0, 7, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 10, 1'b1, 1'b0);
        idle(1'b0);
        idle(1'b1);
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);

        // Pointer wrap: fill, drain two, add two, drain all.
        for (int i = 11; i <= 14; i++) cycle(1'b1, 1'b0, i, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 2, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 0, 1'b1, 1'b0);

        // Both channels non-empty, then asynchronous reset between edges.
        cycle(1'b1, 1'b0, 3, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 4, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 5, 1'b0, 1'b1);
        @(posedge clk);
        #2;
        wr_req = 1'b0;
        r_req  = 1'b0;
        a_rst  = 1'b1;
        #1;
        chk_reset_state("async");
        mq0.delete();
        mq1.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        #4;
        a_rst = 1'b0;
        cycle(1'b0, 1'b0, 0, 1'b1, 1'b1);
        idle(1'b1);
        cycle(1'b1, 1'b1, 9, 1'b0, 1'b1);
        idle(1'b1);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++)
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        idle(1'b0);
        @(negedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_queue.md
VC_QUEUE -- requirements
Module: vc_queue

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 4, payload width in bits.
REQ-002 SHALL have parameter PTR_SIZE, default 2, per-channel depth DEPTH = 2^PTR_SIZE entries.
REQ-003 SHALL have parameter CH_NUM, default 4, number of independent channels (2..16).
REQ-004 SHALL have parameter CH_W, default 2, channel-select width, ceil(log2(CH_NUM)).
REQ-005 SHALL have parameter AF_LEVEL, default 3, almost-full threshold in entries (1..DEPTH).
REQ-006 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-007 SHALL have port a_rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port wr_req  input  1  write strobe.
REQ-009 SHALL have port wr_ch  input  CH_W  target channel of the write.
REQ-010 SHALL have port data_i  input  DATA_SIZE  write data.
REQ-011 SHALL have port r_req  input  1  read (pop) strobe.
REQ-012 SHALL have port r_ch  input  CH_W  channel to read.
REQ-013 SHALL have port data_o  output  DATA_SIZE  head entry of channel r_ch.
REQ-014 SHALL have port full  output  CH_NUM  per-channel full flags, bit i = channel i.
REQ-015 SHALL have port empty  output  CH_NUM  per-channel empty flags.
REQ-016 SHALL have port almost_full  output  CH_NUM  per-channel count >= AF_LEVEL.
REQ-017 SHALL have port count  output  CH_NUM*(PTR_SIZE+1)  per-channel occupancy, channel i in bits [i*(PTR_SIZE+1) +: PTR_SIZE+1].

Function
REQ-018 Each channel SHALL be a separate circular FIFO of DEPTH entries, with its own write pointer, read pointer and count; pointers wrap modulo DEPTH.
REQ-019 Write with wr_req=1 to a channel not full SHALL store data_i at that channel's write pointer and advance it on the clock edge.
REQ-020 Write to a full channel SHALL be dropped: no state change, even with a simultaneous read of the same channel.
REQ-021 Read with r_req=1 from a non-empty channel SHALL advance its read pointer on the clock edge; read of an empty channel SHALL be ignored, even with a simultaneous write to it.
REQ-022 Accepted read and write on the same channel in one cycle SHALL both take effect; count unchanged.
REQ-023 Accepted read and write on different channels SHALL act independently.
REQ-024 data_o SHALL combinationally show the head of channel r_ch (zero read latency, first-word-fall-through); if that channel is empty data_o SHALL be 0.
REQ-025 full[i] = (count_i == DEPTH); empty[i] = (count_i == 0); almost_full[i] = (count_i >= AF_LEVEL); all derived from registered counts, updated the cycle after the access.
REQ-026 wr_ch or r_ch >= CH_NUM SHALL be treated as no access.

Reset
REQ-027 a_rst=1 SHALL immediately clear all pointers and counts, giving empty = all ones, full = 0, almost_full = 0, count = 0, data_o = 0.
REQ-028 Reset asserted mid-operation SHALL discard all stored data; storage array contents are not reset and not observable afterwards.
REQ-029 First accesses SHALL be accepted on the first rising edge after a_rst deasserts.

Configuration
REQ-030 Macro VC_QUEUE_ERR_EN defined: adds outputs err_ovf and err_udf, 1 bit each, sticky, cleared only by a_rst; err_ovf sets on a dropped write to a full channel; err_udf sets on an ignored read of an empty channel; both set the edge after the event.
REQ-031 VC_QUEUE_ERR_EN undefined: ports err_ovf/err_udf and their logic SHALL be absent; all other behaviour identical.

Verification (DATA_SIZE=4, PTR_SIZE=2, CH_NUM=2, CH_W=1, AF_LEVEL=3)
REQ-032 Reset then idle -> empty=2'b11, full=2'b00, count=0, data_o=0.
REQ-033 Write 1,2,3,4 to ch0 -> after 3rd write almost_full[0]=1; after 4th full=2'b01; count ch0=4; ch1 still empty; read ch0 4 times gives data_o 1,2,3,4, then empty[0]=1, data_o=0.
REQ-034 ch0 full, write 5 with simultaneous read of ch0 -> read accepted, 5 dropped, count ch0=3; with VC_QUEUE_ERR_EN err_ovf=1.
REQ-035 Write ch1=A and read ch0 (holding 7) same cycle -> data_o becomes 0 for r_ch=0, ch1 holds A, count ch1=1.
REQ-036 Fill ch0, drain 2, write 2 more (pointer wrap) -> reads return correct FIFO order across wrap.
REQ-037 Assert a_rst between clock edges with both channels non-empty -> flags/count/data_o reset immediately without a clock; read of empty ch1 afterwards sets err_udf only with VC_QUEUE_ERR_EN.
